// File: rtl/snitch_icache_refill_writer_pkg.sv
// snitch_icache_refill_writer_pkg: shared icache refill types and default geometry.
package snitch_icache_refill_writer_pkg;

    function automatic int way_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int DEF_LINE_WIDTH = 128;
    localparam int DEF_FILL_WIDTH = 64;
    localparam int DEF_WAY_COUNT  = 4;
    localparam int DEF_LINE_COUNT = 128;
    localparam int DEF_ADDR_WIDTH = $clog2(DEF_LINE_COUNT);
    localparam int DEF_WAY_WIDTH  = way_bits(DEF_WAY_COUNT);

    typedef enum logic [1:0] {IDLE, COLLECT, WRITE, DONE} state_e;

    typedef struct packed {
        logic [DEF_WAY_WIDTH-1:0]  way;
        logic [DEF_ADDR_WIDTH-1:0] addr;
    } refill_cmd_t;

    typedef struct packed {
        logic [DEF_WAY_WIDTH-1:0]  way;
        logic [DEF_ADDR_WIDTH-1:0] addr;
        logic                      error;
    } refill_done_t;

endpackage

// File: rtl/snitch_icache_refill_writer_if.sv
// snitch_icache_refill_writer_if: command, beat, data-memory write and completion channels.
interface snitch_icache_refill_writer_if
    import snitch_icache_refill_writer_pkg::*;
#(
    parameter int LINE_WIDTH = DEF_LINE_WIDTH,
    parameter int FILL_WIDTH = DEF_FILL_WIDTH,
    parameter int WAY_COUNT  = DEF_WAY_COUNT,
    parameter int LINE_COUNT = DEF_LINE_COUNT,
    localparam int ADDR_WIDTH = $clog2(LINE_COUNT),
    localparam int WAY_WIDTH  = way_bits(WAY_COUNT)
);
    logic                  cmd_valid_i;
    logic                  cmd_ready_o;
    logic [WAY_WIDTH-1:0]  cmd_way_i;
    logic [ADDR_WIDTH-1:0] cmd_addr_i;
    logic                  beat_valid_i;
    logic                  beat_ready_o;
    logic [FILL_WIDTH-1:0] beat_data_i;
    logic                  beat_last_i;
    logic                  beat_error_i;
    logic                  ram_req_o;
    logic                  ram_gnt_i;
    logic [WAY_COUNT-1:0]  ram_enable_o;
    logic                  ram_write_o;
    logic [ADDR_WIDTH-1:0] ram_addr_o;
    logic [LINE_WIDTH-1:0] ram_wdata_o;
    logic                  done_valid_o;
    logic                  done_ready_i;
    logic [WAY_WIDTH-1:0]  done_way_o;
    logic [ADDR_WIDTH-1:0] done_addr_o;
    logic                  done_error_o;

    modport slave (
        input  cmd_valid_i, cmd_way_i, cmd_addr_i,
        input  beat_valid_i, beat_data_i, beat_last_i, beat_error_i,
        input  ram_gnt_i, done_ready_i,
        output cmd_ready_o, beat_ready_o,
        output ram_req_o, ram_enable_o, ram_write_o, ram_addr_o, ram_wdata_o,
        output done_valid_o, done_way_o, done_addr_o, done_error_o
    );

    modport master (
        output cmd_valid_i, cmd_way_i, cmd_addr_i,
        output beat_valid_i, beat_data_i, beat_last_i, beat_error_i,
        output ram_gnt_i, done_ready_i,
        input  cmd_ready_o, beat_ready_o,
        input  ram_req_o, ram_enable_o, ram_write_o, ram_addr_o, ram_wdata_o,
        input  done_valid_o, done_way_o, done_addr_o, done_error_o
    );
endinterface

// File: rtl/snitch_icache_refill_writer.sv
// snitch_icache_refill_writer: packs refill beats into a cache line, writes it to the
// data memory on grant and reports completion (with error) to the lookup stage.
module snitch_icache_refill_writer
    import snitch_icache_refill_writer_pkg::*;
#(
    parameter int LINE_WIDTH = DEF_LINE_WIDTH,
    parameter int FILL_WIDTH = DEF_FILL_WIDTH,
    parameter int WAY_COUNT  = DEF_WAY_COUNT,
    parameter int LINE_COUNT = DEF_LINE_COUNT
) (
    input logic clk_i,
    input logic rst_ni,
    snitch_icache_refill_writer_if.slave bus
);
    localparam int BEATS     = LINE_WIDTH / FILL_WIDTH;
    localparam int CNT_WIDTH = $clog2(BEATS + 1);

    state_e                r_state;
    logic                  r_cmd_ready;
    logic                  r_beat_ready;
    logic                  r_ram_req;
    logic                  r_done_valid;
    refill_cmd_t           r_cmd;
    logic                  r_err;
    logic [CNT_WIDTH-1:0]  r_cnt;
    logic [LINE_WIDTH-1:0] r_line;

    logic         w_beat_hs;
    logic         w_beat_err;
    logic         w_gnt;
    refill_done_t w_done;

    assign w_beat_hs  = bus.beat_valid_i & r_beat_ready;
    // overflow beat, bad last position, or bus error all poison the line
    assign w_beat_err = bus.beat_error_i | (int'(r_cnt) >= BEATS)
                      | (bus.beat_last_i & (int'(r_cnt) + 1 != BEATS));
    assign w_gnt      = r_ram_req & bus.ram_gnt_i;
    assign w_done     = '{way: r_cmd.way, addr: r_cmd.addr, error: r_err};

    assign bus.cmd_ready_o  = r_cmd_ready;
    assign bus.beat_ready_o = r_beat_ready;
    assign bus.ram_req_o    = r_ram_req;
    assign bus.ram_enable_o = w_gnt ? WAY_COUNT'(1) << r_cmd.way : '0;
    assign bus.ram_write_o  = w_gnt;
    assign bus.ram_addr_o   = r_cmd.addr;
    assign bus.ram_wdata_o  = r_line;
    assign bus.done_valid_o = r_done_valid;
    assign bus.done_way_o   = w_done.way;
    assign bus.done_addr_o  = w_done.addr;
    assign bus.done_error_o = w_done.error;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state      <= IDLE;
            r_cmd_ready  <= 1'b1;
            r_beat_ready <= 1'b0;
            r_ram_req    <= 1'b0;
            r_done_valid <= 1'b0;
            r_cmd        <= '0;
            r_err        <= 1'b0;
            r_cnt        <= '0;
            r_line       <= '0;
        end else begin
            for (int b = 0; b < BEATS; b++)
                if (w_beat_hs && r_cnt == CNT_WIDTH'(b))
                    r_line[b*FILL_WIDTH +: FILL_WIDTH] <= bus.beat_data_i;
            case (r_state)
                IDLE: if (bus.cmd_valid_i) begin
                    r_cmd        <= '{way: bus.cmd_way_i, addr: bus.cmd_addr_i};
                    r_cnt        <= '0;
                    r_err        <= 1'b0;
                    r_cmd_ready  <= 1'b0;
                    r_beat_ready <= 1'b1;
                    r_state      <= COLLECT;
                end
                COLLECT: if (w_beat_hs) begin
                    r_cnt <= (int'(r_cnt) >= BEATS) ? r_cnt : r_cnt + 1'b1;
                    r_err <= r_err | w_beat_err;
                    if (bus.beat_last_i) begin
                        r_beat_ready <= 1'b0;
                        r_ram_req    <= ~(r_err | w_beat_err);
                        r_done_valid <= r_err | w_beat_err;
                        r_state      <= (r_err | w_beat_err) ? DONE : WRITE;
                    end
                end
                WRITE: if (bus.ram_gnt_i) begin
                    r_ram_req    <= 1'b0;
                    r_done_valid <= 1'b1;
                    r_state      <= DONE;
                end
                DONE: if (bus.done_ready_i) begin
                    r_done_valid <= 1'b0;
                    r_cmd_ready  <= 1'b1;
                    r_state      <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_snitch_icache_refill_writer.sv
// tb_snitch_icache_refill_writer: directed refill scenarios with hand-computed expectations.
module tb_snitch_icache_refill_writer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    logic seen_write = 1'b0;

    always #5 clk = ~clk;

    snitch_icache_refill_writer_if bus ();

    snitch_icache_refill_writer dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (bus)
    );

    always @(negedge clk) if (bus.ram_write_o === 1'b1) seen_write = 1'b1;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cmd(input logic [1:0] way, input logic [6:0] addr);
        bus.cmd_valid_i = 1'b1;
        bus.cmd_way_i   = way;
        bus.cmd_addr_i  = addr;
        step();
        bus.cmd_valid_i = 1'b0;
    endtask

    task automatic beat(input logic [63:0] d, input logic last, input logic err);
        bus.beat_valid_i = 1'b1;
        bus.beat_data_i  = d;
        bus.beat_last_i  = last;
        bus.beat_error_i = err;
        step();
        bus.beat_valid_i = 1'b0;
        bus.beat_last_i  = 1'b0;
        bus.beat_error_i = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " cmd_ready"}, 128'(bus.cmd_ready_o), 128'd1);
        chk({tag, " beat_ready"}, 128'(bus.beat_ready_o), 128'd0);
        chk({tag, " ram_req"}, 128'(bus.ram_req_o), 128'd0);
        chk({tag, " ram_enable"}, 128'(bus.ram_enable_o), 128'd0);
        chk({tag, " ram_write"}, 128'(bus.ram_write_o), 128'd0);
        chk({tag, " done_valid"}, 128'(bus.done_valid_o), 128'd0);
        chk({tag, " ram_addr"}, 128'(bus.ram_addr_o), 128'd0);
        chk({tag, " ram_wdata"}, bus.ram_wdata_o, 128'd0);
        chk({tag, " done_way"}, 128'(bus.done_way_o), 128'd0);
        chk({tag, " done_addr"}, 128'(bus.done_addr_o), 128'd0);
    endtask

    initial begin
        bus.cmd_valid_i  = 1'b0;
        bus.cmd_way_i    = '0;
        bus.cmd_addr_i   = '0;
        bus.beat_valid_i = 1'b0;
        bus.beat_data_i  = '0;
        bus.beat_last_i  = 1'b0;
        bus.beat_error_i = 1'b0;
        bus.ram_gnt_i    = 1'b1;
        bus.done_ready_i = 1'b0;
        step();
        step();
        chk_reset_outputs("reset");
        rst_n = 1'b1;
        step();

        // basic refill, grant held high
        cmd(2'd2, 7'h15);
        chk("t1 cmd_ready in collect", 128'(bus.cmd_ready_o), 128'd0);
        chk("t1 beat_ready in collect", 128'(bus.beat_ready_o), 128'd1);
        beat(64'h1111_1111_2222_2222, 1'b0, 1'b0);
        beat(64'h3333_3333_4444_4444, 1'b1, 1'b0);
        chk("t1 ram_req", 128'(bus.ram_req_o), 128'd1);
        chk("t1 ram_write", 128'(bus.ram_write_o), 128'd1);
        chk("t1 ram_enable", 128'(bus.ram_enable_o), 128'b0100);
        chk("t1 ram_addr", 128'(bus.ram_addr_o), 128'h15);
        chk("t1 ram_wdata", bus.ram_wdata_o, 128'h3333_3333_4444_4444_1111_1111_2222_2222);
        chk("t1 done early", 128'(bus.done_valid_o), 128'd0);
        step();
        chk("t1 done_valid", 128'(bus.done_valid_o), 128'd1);
        chk("t1 done_error", 128'(bus.done_error_o), 128'd0);
        chk("t1 done_way", 128'(bus.done_way_o), 128'd2);
        chk("t1 done_addr", 128'(bus.done_addr_o), 128'h15);
        chk("t1 write once", 128'(bus.ram_write_o), 128'd0);
        bus.done_ready_i = 1'b1;
        step();
        bus.done_ready_i = 1'b0;
        chk("t1 back idle", 128'(bus.cmd_ready_o), 128'd1);
        chk("t1 done cleared", 128'(bus.done_valid_o), 128'd0);

        // grant withheld for five cycles
        bus.ram_gnt_i = 1'b0;
        cmd(2'd1, 7'h40);
        beat(64'hDEAD_BEEF_0000_0001, 1'b0, 1'b0);
        beat(64'hCAFE_F00D_0000_0002, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            chk("t2 req held", 128'(bus.ram_req_o), 128'd1);
            chk("t2 enable low", 128'(bus.ram_enable_o), 128'd0);
            chk("t2 write low", 128'(bus.ram_write_o), 128'd0);
            step();
        end
        bus.ram_gnt_i = 1'b1;
        #1;
        chk("t2 write on grant", 128'(bus.ram_write_o), 128'd1);
        chk("t2 enable on grant", 128'(bus.ram_enable_o), 128'b0010);
        chk("t2 wdata", bus.ram_wdata_o, 128'hCAFE_F00D_0000_0002_DEAD_BEEF_0000_0001);
        step();
        chk("t2 done_valid", 128'(bus.done_valid_o), 128'd1);
        chk("t2 req dropped", 128'(bus.ram_req_o), 128'd0);
        bus.done_ready_i = 1'b1;
        step();
        bus.done_ready_i = 1'b0;

        // bus error on second beat
        seen_write = 1'b0;
        cmd(2'd1, 7'h7F);
        beat(64'h5555_5555_5555_5555, 1'b0, 1'b0);
        beat(64'h6666_6666_6666_6666, 1'b1, 1'b1);
        chk("t3 done_valid", 128'(bus.done_valid_o), 128'd1);
        chk("t3 done_error", 128'(bus.done_error_o), 128'd1);
        chk("t3 done_way", 128'(bus.done_way_o), 128'd1);
        chk("t3 done_addr", 128'(bus.done_addr_o), 128'h7F);
        chk("t3 no req", 128'(bus.ram_req_o), 128'd0);
        bus.done_ready_i = 1'b1;
        step();
        bus.done_ready_i = 1'b0;
        chk("t3 no write", 128'(seen_write), 128'd0);

        // last on beat 0
        seen_write = 1'b0;
        cmd(2'd0, 7'h03);
        beat(64'h7777_7777_7777_7777, 1'b1, 1'b0);
        chk("t4 short done", 128'(bus.done_valid_o), 128'd1);
        chk("t4 short error", 128'(bus.done_error_o), 128'd1);
        bus.done_ready_i = 1'b1;
        step();
        bus.done_ready_i = 1'b0;
        chk("t4 short no write", 128'(seen_write), 128'd0);

        // three beats, last on the third
        seen_write = 1'b0;
        cmd(2'd3, 7'h04);
        beat(64'h1, 1'b0, 1'b0);
        beat(64'h2, 1'b0, 1'b0);
        chk("t4 third beat ready", 128'(bus.beat_ready_o), 128'd1);
        beat(64'h3, 1'b1, 1'b0);
        chk("t4 long done", 128'(bus.done_valid_o), 128'd1);
        chk("t4 long error", 128'(bus.done_error_o), 128'd1);
        chk("t4 long beat_ready off", 128'(bus.beat_ready_o), 128'd0);
        bus.done_ready_i = 1'b1;
        step();
        bus.done_ready_i = 1'b0;
        chk("t4 long no write", 128'(seen_write), 128'd0);

        // completion back-pressure with a second command waiting
        cmd(2'd3, 7'h01);
        beat(64'hAAAA_0000_AAAA_0000, 1'b0, 1'b0);
        beat(64'hBBBB_0000_BBBB_0000, 1'b1, 1'b0);
        step();
        bus.cmd_valid_i = 1'b1;
        bus.cmd_way_i   = 2'd0;
        bus.cmd_addr_i  = 7'h22;
        for (int i = 0; i < 4; i++) begin
            chk("t5 done held", 128'(bus.done_valid_o), 128'd1);
            chk("t5 way stable", 128'(bus.done_way_o), 128'd3);
            chk("t5 addr stable", 128'(bus.done_addr_o), 128'h01);
            chk("t5 error stable", 128'(bus.done_error_o), 128'd0);
            chk("t5 cmd blocked", 128'(bus.cmd_ready_o), 128'd0);
            step();
        end
        bus.done_ready_i = 1'b1;
        step();
        bus.done_ready_i = 1'b0;
        chk("t5 cmd_ready after done", 128'(bus.cmd_ready_o), 128'd1);
        step();
        bus.cmd_valid_i = 1'b0;
        chk("t5 second cmd accepted", 128'(bus.beat_ready_o), 128'd1);
        chk("t5 second cmd addr", 128'(bus.ram_addr_o), 128'h22);

        // asynchronous reset after the first beat
        beat(64'h9999_9999_9999_9999, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("mid reset");
        step();
        rst_n = 1'b1;
        step();
        seen_write = 1'b0;
        cmd(2'd1, 7'h33);
        beat(64'h0123_4567_89AB_CDEF, 1'b0, 1'b0);
        beat(64'hFEDC_BA98_7654_3210, 1'b1, 1'b0);
        chk("t6 write", 128'(bus.ram_write_o), 128'd1);
        chk("t6 enable", 128'(bus.ram_enable_o), 128'b0010);
        chk("t6 addr", 128'(bus.ram_addr_o), 128'h33);
        chk("t6 wdata", bus.ram_wdata_o, 128'hFEDC_BA98_7654_3210_0123_4567_89AB_CDEF);
        step();
        chk("t6 done_valid", 128'(bus.done_valid_o), 128'd1);
        chk("t6 done_error", 128'(bus.done_error_o), 128'd0);
        chk("t6 done_addr", 128'(bus.done_addr_o), 128'h33);
        bus.done_ready_i = 1'b1;
        step();
        bus.done_ready_i = 1'b0;
        chk("t6 idle", 128'(bus.cmd_ready_o), 128'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
